draw_layer_arbiter: RTL

- Registered, reprogrammable priority arbiter for the VGA drawing chain; replaces fixed-order border/object muxing.
- Each cycle, picks the highest-priority layer asserting its draw request and forwards that layer's RGB.
- Software/game FSM loads a new priority order through a valid/ready handshake; the order takes effect only on a frame boundary, so no frame tears.

---
 rtl/draw_layer_pkg.sv | 38 +++
 rtl/draw_layer_arbiter_prio_select.sv | 30 +++
 rtl/draw_layer_arbiter.sv | 139 +++++++++++++
 3 files changed

// File: rtl/draw_layer_pkg.sv
// Shared types, defaults and the permutation check for the draw-layer arbiter.
// Optional blink feature (LAYER_BLINK_EN) lives in draw_layer_arbiter.
package draw_layer_pkg;

  localparam int NUM_LAYERS_DEF = 4;
  localparam int IDX_W_DEF      = 2;
  localparam int MAX_LAYERS     = 16;

  typedef logic [IDX_W_DEF-1:0] layer_idx_t;
  typedef layer_idx_t [NUM_LAYERS_DEF-1:0] prio_order_t;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } cfg_state_t;

  // flat holds n slots of w bits each, slot 0 in the LSBs.
  function automatic logic is_permutation(input logic [63:0] flat,
                                          input int unsigned n,
                                          input int unsigned w);
    logic [MAX_LAYERS-1:0] seen;
    logic                  ok;
    logic [63:0]           slot;
    seen = '0;
    ok   = 1'b1;
    slot = '0;
    for (int unsigned k = 0; k < MAX_LAYERS; k++) begin
      if (k < n) begin
        slot = (flat >> (k * w)) & ((64'd1 << w) - 64'd1);
        if (slot >= 64'(n))          ok = 1'b0;
        else if (seen[slot[3:0]])    ok = 1'b0;
        else                         seen[slot[3:0]] = 1'b1;
      end
    end
    return ok;
  endfunction

endpackage

// File: rtl/draw_layer_arbiter_prio_select.sv
// Combinational priority scan: first slot of the order whose layer requests wins.
module prio_select
  import draw_layer_pkg::*;
#(
  parameter int NUM_LAYERS = NUM_LAYERS_DEF,
  parameter int IDX_W      = IDX_W_DEF
) (
  input  logic [IDX_W*NUM_LAYERS-1:0] order_i,
  input  logic [NUM_LAYERS-1:0]       req_i,
  output logic                        hit_o,
  output logic [IDX_W-1:0]            idx_o
);

  logic [IDX_W-1:0] slot;

  // Walk from the lowest priority upward so slot 0 overrides everything.
  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    slot  = '0;
    for (int k = NUM_LAYERS - 1; k >= 0; k--) begin
      slot = order_i[IDX_W*k +: IDX_W];
      if (32'(slot) < NUM_LAYERS && req_i[slot]) begin
        hit_o = 1'b1;
        idx_o = slot;
      end
    end
  end

endmodule

// File: rtl/draw_layer_arbiter.sv
// Registered, reprogrammable layer priority arbiter; new orders commit on startOfFrame.
// Define LAYER_BLINK_EN to add blink_mask and a 5-bit frame counter gating masked layers.
module draw_layer_arbiter
  import draw_layer_pkg::*;
#(
  parameter int         NUM_LAYERS = NUM_LAYERS_DEF,
  parameter int         IDX_W      = IDX_W_DEF,
  parameter logic [7:0] BG_RGB     = 8'h00
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        startOfFrame,
  input  logic [NUM_LAYERS-1:0]       layer_DR,
  input  logic [8*NUM_LAYERS-1:0]     layer_RGB,
`ifdef LAYER_BLINK_EN
  input  logic [NUM_LAYERS-1:0]       blink_mask,
`endif
  input  logic                        cfg_valid,
  input  logic [IDX_W*NUM_LAYERS-1:0] cfg_order,
  output logic                        cfg_ready,
  output logic                        cfg_err,
  output logic                        cfg_pending,
  output logic [7:0]                  RGBOut,
  output logic                        layer_hit,
  output logic [IDX_W-1:0]            hit_index
);

  localparam int OW = IDX_W * NUM_LAYERS;

  function automatic logic [OW-1:0] identity_order();
    logic [OW-1:0] o;
    o = '0;
    for (int k = 0; k < NUM_LAYERS; k++) o[IDX_W*k +: IDX_W] = IDX_W'(k);
    return o;
  endfunction

  localparam logic [OW-1:0] IDENT = identity_order();

  cfg_state_t       state_q, state_d;
  logic [OW-1:0]    act_q, act_d;
  logic [OW-1:0]    shadow_q, shadow_d;
  logic             err_q, err_d;
  logic [7:0]       rgb_q, rgb_d;
  logic             hit_q;
  logic [IDX_W-1:0] idx_q;
  logic [NUM_LAYERS-1:0] req_eff;
  logic             win_hit;
  logic [IDX_W-1:0] win_idx;
  logic             xfer;
  logic             perm_ok;

`ifdef LAYER_BLINK_EN
  logic [4:0] frame_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)             frame_q <= '0;
    else if (startOfFrame) frame_q <= frame_q + 5'd1;
  end

  // Second half of each 32-frame period hides the masked layers.
  assign req_eff = frame_q[4] ? (layer_DR & ~blink_mask) : layer_DR;
`else
  assign req_eff = layer_DR;
`endif

  prio_select #(
    .NUM_LAYERS (NUM_LAYERS),
    .IDX_W      (IDX_W)
  ) u_prio_select (
    .order_i (act_q),
    .req_i   (req_eff),
    .hit_o   (win_hit),
    .idx_o   (win_idx)
  );

  assign cfg_ready   = (state_q == IDLE);
  assign cfg_pending = (state_q == PENDING);
  assign xfer        = cfg_valid && cfg_ready;
  assign perm_ok     = is_permutation(64'(cfg_order), NUM_LAYERS, IDX_W);

  always_comb begin
    state_d  = state_q;
    act_d    = act_q;
    shadow_d = shadow_q;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (xfer) begin
          if (perm_ok) begin
            shadow_d = cfg_order;
            state_d  = PENDING;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      PENDING: begin
        if (startOfFrame) begin
          act_d   = shadow_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rgb_d = BG_RGB;
    for (int k = 0; k < NUM_LAYERS; k++) begin
      if (win_hit && 32'(win_idx) == k) rgb_d = layer_RGB[8*k +: 8];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      act_q    <= IDENT;
      shadow_q <= IDENT;
      err_q    <= 1'b0;
      rgb_q    <= BG_RGB;
      hit_q    <= 1'b0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      act_q    <= act_d;
      shadow_q <= shadow_d;
      err_q    <= err_d;
      rgb_q    <= rgb_d;
      hit_q    <= win_hit;
      idx_q    <= win_idx;
    end
  end

  assign cfg_err   = err_q;
  assign RGBOut    = rgb_q;
  assign layer_hit = hit_q;
  assign hit_index = idx_q;

endmodule
